// File: rtl/motor_pkg.sv
// Shared types and helpers for the H-bridge motor PWM driver.
package motor_pkg;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DEAD
    } state_t;

    // |speed| clamped to limit; the most negative command lands on the clamp too.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] speed,
                                            input logic [31:0] limit);
        logic [31:0] mag;
        mag = speed[31] ? $unsigned(-speed) : $unsigned(speed);
        return (mag > limit) ? limit : mag;
    endfunction

endpackage

// File: rtl/motor_pwm_driver_timebase.sv
// PWM timebase: clk prescaler, period counter and a registered period_start pulse.
module pwm_timebase #(
    parameter int CLK_DIV = 50,
    parameter int PERIOD  = 1000,
    parameter int CNT_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             period_start
);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             wrap;

    assign tick = (pre == PRE_W'(CLK_DIV - 1));
    assign wrap = tick && (cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre          <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            pre          <= tick ? '0 : pre + PRE_W'(1);
            // pulse lines up with the first clk of cnt == 0
            period_start <= wrap;
            if (tick)
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// One H-bridge channel: signed speed command -> PWM + INA/INB with reversal coast.
// Optional build macro MOTOR_SOFT_START_EN ramps the applied duty by RAMP_STEP per period.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int CLK_DIV          = 50,
    parameter int PERIOD           = 1000,
    parameter int DUTY_W           = 10,
    parameter int DEADTIME_PERIODS = 2,
    parameter int RAMP_STEP        = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [DUTY_W:0] cmd_speed,
    output logic            pwm,
    output logic            ina,
    output logic            inb,
    output logic            period_start,
    output logic            busy
);
    localparam int CNT_W = DUTY_W + 1;
    localparam int DC_W  = $clog2(DEADTIME_PERIODS + 1);
    localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);
`ifdef MOTOR_SOFT_START_EN
    localparam bit SOFT_START = 1'b1;
`else
    localparam bit SOFT_START = 1'b0;
`endif

    logic [CNT_W-1:0] cnt;
    state_t           state_q, state_d;
    dir_t             dir_q, dir_d, pend_dir_q, new_dir;
    logic [CNT_W-1:0] duty_q, duty_d, tgt_q, tgt_d, pend_mag_q, duty_base;
    logic [DC_W-1:0]  dead_q, dead_d;
    logic             pend_vld_q, apply;

    pwm_timebase #(.CLK_DIV(CLK_DIV), .PERIOD(PERIOD), .CNT_W(CNT_W)) u_tb (
        .clk          (clk),
        .reset        (reset),
        .cnt          (cnt),
        .period_start (period_start)
    );

    function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] cur, input logic [CNT_W-1:0] tgt);
        if (cur < tgt)
            return ((tgt - cur) > STEP) ? cur + STEP : tgt;
        return ((cur - tgt) > STEP) ? cur - STEP : tgt;
    endfunction

    assign cmd_ready = !pend_vld_q && (state_q != ST_DEAD);
    assign busy      = (state_q == ST_DEAD) || pend_vld_q || (SOFT_START && (duty_q != tgt_q));
    // a zero-speed command never flips the bridge
    assign new_dir   = (pend_mag_q == '0) ? dir_q : pend_dir_q;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        tgt_d     = tgt_q;
        duty_d    = duty_q;
        dead_d    = dead_q;
        apply     = 1'b0;
        duty_base = (state_q == ST_RUN) ? duty_q : '0;
        if (period_start) begin
            unique case (state_q)
                ST_IDLE: if (pend_vld_q) begin
                    state_d = ST_RUN;
                    dir_d   = new_dir;
                    tgt_d   = pend_mag_q;
                    apply   = 1'b1;
                end
                ST_RUN: if (pend_vld_q) begin
                    if (new_dir != dir_q) begin
                        state_d = ST_DEAD;
                        dead_d  = DC_W'(DEADTIME_PERIODS);
                    end else begin
                        tgt_d = pend_mag_q;
                        apply = 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (dead_q <= DC_W'(1)) begin
                        state_d = ST_RUN;
                        dir_d   = new_dir;
                        tgt_d   = pend_mag_q;
                        apply   = 1'b1;
                    end else begin
                        dead_d = dead_q - DC_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_d == ST_RUN)
                duty_d = SOFT_START ? ramp(duty_base, tgt_d) : tgt_d;
            else
                duty_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_FWD;
            duty_q     <= '0;
            tgt_q      <= '0;
            dead_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= DIR_FWD;
            pend_mag_q <= '0;
            pwm        <= 1'b0;
            ina        <= 1'b0;
            inb        <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            dead_q  <= dead_d;
            if (apply) begin
                pend_vld_q <= 1'b0;
            end else if (cmd_valid && cmd_ready) begin
                pend_vld_q <= 1'b1;
                pend_dir_q <= cmd_speed[DUTY_W] ? DIR_REV : DIR_FWD;
                pend_mag_q <= CNT_W'(abs_sat(32'($signed(cmd_speed)), 32'(PERIOD)));
            end
            pwm <= (state_q == ST_RUN) && enable && (cnt < duty_q);
            ina <= (state_d == ST_RUN) && (dir_d == DIR_FWD);
            inb <= (state_d == ST_RUN) && (dir_d == DIR_REV);
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with small sim parameters (20 clk PWM period).
module tb_motor_pwm_driver;
    logic       clk = 1'b0;
    logic       reset, enable, cmd_valid;
    logic [4:0] cmd_speed;
    logic       cmd_ready, pwm, ina, inb, period_start, busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .CLK_DIV(2), .PERIOD(10), .DUTY_W(4), .DEADTIME_PERIODS(2), .RAMP_STEP(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_speed    (cmd_speed),
        .pwm          (pwm),
        .ina          (ina),
        .inb          (inb),
        .period_start (period_start),
        .busy         (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // advance to the next period_start strictly after the current cycle
    task automatic wait_ps(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!period_start && n < 100);
        if (!period_start) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic send(input logic [4:0] v);
        cmd_valid = 1'b1;
        cmd_speed = v;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic pwm_count(input int len, output int n);
        n = 0;
        for (int i = 0; i < len; i++) begin
            if (pwm) n++;
            step();
        end
    endtask

    // from the first DEAD cycle, count coast cycles until a direction pin rises
    task automatic dead_len(output int n, output int bad);
        n = 1;
        bad = 0;
        step();
        while (!(ina || inb) && n < 100) begin
            if (pwm || cmd_ready) bad++;
            n++;
            step();
        end
    endtask

    initial begin
        int n, bad;
        reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_speed = '0;
        repeat (3) step();
        chk("rst_ina", ina, 0);
        chk("rst_inb", inb, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ps", period_start, 0);
        reset = 1'b0;

        wait_ps("ps0");
        n = 0;
        do begin step(); n++; end while (!period_start && n < 100);
        chk("ps_spacing", n, 20);

`ifdef MOTOR_SOFT_START_EN
        send(5'd9);
        wait_ps("ss_apply");
        step();
        chk("ss_ina", ina, 1);
        chk("ss_ready_in_ramp", cmd_ready, 1);
        chk("ss_busy_in_ramp", busy, 1);
        wait_ps("ss_p2");
        pwm_count(20, n);
        chk("ss_duty6", n, 12);
        pwm_count(20, n);
        chk("ss_duty9", n, 18);
        chk("ss_busy_done", busy, 0);
`else
        // command lands on a period_start cycle: held until the next boundary
        send(5'd4);
        chk("p4_ready_drop", cmd_ready, 0);
        chk("p4_busy", busy, 1);
        chk("p4_not_yet", ina, 0);
        wait_ps("p4_apply");
        step();
        chk("p4_ina", ina, 1);
        chk("p4_inb", inb, 0);
        chk("p4_ready_back", cmd_ready, 1);
        chk("p4_busy_clr", busy, 0);
        wait_ps("p4_meas");
        pwm_count(20, n);
        chk("p4_high", n, 8);

        send(5'h1A);  // -6: reversal
        wait_ps("m6_dead");
        step();
        chk("m6_dead_ina", ina, 0);
        chk("m6_dead_inb", inb, 0);
        dead_len(n, bad);
        chk("m6_dead_len", n, 40);
        chk("m6_dead_quiet", bad, 0);
        chk("m6_ina", ina, 0);
        chk("m6_inb", inb, 1);
        wait_ps("m6_meas");
        pwm_count(20, n);
        chk("m6_high", n, 12);

        // reversal back to +4 with +2 held on the bus through the coast
        send(5'd4);
        cmd_valid = 1'b1;
        cmd_speed = 5'd2;
        wait_ps("hold_dead");
        step();
        dead_len(n, bad);
        chk("hold_dead_len", n, 40);
        chk("hold_no_accept", bad, 0);
        chk("hold_fwd", ina, 1);
        chk("hold_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("hold_taken", cmd_ready, 0);
        wait_ps("p2_apply");
        wait_ps("p2_meas");
        pwm_count(20, n);
        chk("p2_high", n, 4);

        send(5'd10);
        wait_ps("p10_apply");
        wait_ps("p10_meas");
        pwm_count(40, n);
        chk("p10_full", n, 40);
        repeat (3) step();
        enable = 1'b0;
        step();
        chk("en_low_pwm", pwm, 0);
        chk("en_low_dir", ina, 1);
        step();
        chk("en_low_pwm2", pwm, 0);
        enable = 1'b1;
        step();
        chk("en_back_pwm", pwm, 1);

        send(5'd0);
        wait_ps("z_apply");
        wait_ps("z_meas");
        pwm_count(20, n);
        chk("z_high", n, 0);
        chk("z_keep_dir", ina, 1);

        send(5'h10);  // -16 saturates to full reverse
        wait_ps("m16_dead");
        n = 0;
        do begin step(); n++; end while (!(ina || inb) && n < 100);
        chk("m16_inb", inb, 1);
        chk("m16_ina", ina, 0);
        wait_ps("m16_meas");
        pwm_count(20, n);
        chk("m16_high", n, 20);

        send(5'd4);
        wait_ps("rst_dead");
        repeat (5) step();
        chk("rst_dead_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pwm", pwm, 0);
        chk("mid_rst_ina", ina, 0);
        chk("mid_rst_inb", inb, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_ps", period_start, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    always @(negedge clk) begin
        if (ina && inb) begin
            vectors++;
            miscompares++;
            $error("FAIL ina_inb_both observed=1 expected=0");
        end
    end

endmodule
